// File: rtl/tiny_pkg.sv
// -----------------------------------------------------------------------------
// tiny_pkg
// Shared definitions for the 4-bit tiny processor and its program loader:
//   - loader state enumeration
//   - instruction field widths (INST_W, IMM_W, WORD_W)
//   - opcode constants shared by the processor decoder and program images
//   - modulo-16 checksum accumulate helper
// -----------------------------------------------------------------------------
package tiny_pkg;

    localparam int INST_W = 4;
    localparam int IMM_W  = 4;
    localparam int WORD_W = INST_W + IMM_W;

    // Loader states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } ldr_state_e;

    // Opcodes (INST field, upper nibble of each program word)
    localparam logic [INST_W-1:0] OP_NOP = 4'h0;
    localparam logic [INST_W-1:0] OP_LDI = 4'h1;
    localparam logic [INST_W-1:0] OP_ADD = 4'h2;
    localparam logic [INST_W-1:0] OP_SUB = 4'h3;
    localparam logic [INST_W-1:0] OP_AND = 4'h4;
    localparam logic [INST_W-1:0] OP_OR  = 4'h5;
    localparam logic [INST_W-1:0] OP_XOR = 4'h6;
    localparam logic [INST_W-1:0] OP_OUT = 4'h9;
    localparam logic [INST_W-1:0] OP_JZ  = 4'hE;
    localparam logic [INST_W-1:0] OP_JMP = 4'hF;

    // Checksum accumulate: nibble sum, wraps modulo 16
    function automatic logic [3:0] csum_add(input logic [3:0] acc, input logic [3:0] nib);
        return acc + nib;
    endfunction

endpackage

// File: rtl/tiny_prog_ram.sv
// -----------------------------------------------------------------------------
// tiny_prog_ram
// Program memory: 2^ADDR_W x WORD_W registers, asynchronously cleared to zero,
// one synchronous write port and one combinational read port.
// Ports:
//   clock       rising-edge clock
//   reset_p     asynchronous active-high reset (clears every word)
//   we_i        write enable
//   waddr_i     write address
//   wdata_i     write data
//   raddr_i     read address
//   rdata_o     combinational read data
// -----------------------------------------------------------------------------
module tiny_prog_ram
    import tiny_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset_p,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Storage array: cleared on reset, written one word per accepted low nibble
    always_ff @(posedge clock or posedge reset_p) begin
        if (reset_p) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tiny_prog_loader.sv
// -----------------------------------------------------------------------------
// tiny_prog_loader
// Receives a program image as a nibble stream (high nibble of each word first),
// writes it into tiny_prog_ram, optionally checks a trailing modulo-16 nibble
// checksum, then releases the processor via cpu_run.
// Ports:
//   clock, reset_p      clock and asynchronous active-high reset
//   load_start          single-cycle request to begin/restart a load
//   in_valid/in_data    nibble stream input
//   in_ready            loader accepts a nibble this cycle
//   cpu_addr/cpu_data   processor instruction fetch port (combinational read)
//   cpu_run             processor may run (its reset is !cpu_run | reset_p)
//   busy                load in progress
//   load_done/load_err  result level of the last load
// -----------------------------------------------------------------------------
module tiny_prog_loader
    import tiny_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter bit CSUM_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset_p,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [3:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [WORD_W-1:0] cpu_data,
    output logic              cpu_run,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [3:0]        sum_q,   sum_d;
    logic [3:0]        hi_q,    hi_d;
    logic              we_s;
    logic              accept_s;

    // Status outputs depend on the registered state only
    assign in_ready  = (state_q == ST_HI) || (state_q == ST_LO) || (state_q == ST_CSUM);
    assign busy      = in_ready;
    assign cpu_run   = (state_q == ST_DONE);
    assign load_done = (state_q == ST_DONE);
    assign load_err  = (state_q == ST_ERR);
    assign accept_s  = in_valid && in_ready;

    // Loader state, address counter, running checksum and buffered high nibble
    always_ff @(posedge clock or posedge reset_p) begin
        if (reset_p) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            sum_q   <= 4'h0;
            hi_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            hi_q    <= hi_d;
        end
    end

    // Next-state logic; load_start overrides any accept in the same cycle
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        we_s    = 1'b0;
        if (load_start) begin
            state_d = ST_HI;
            addr_d  = '0;
            sum_d   = 4'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_HI: begin
                    if (accept_s) begin
                        hi_d    = in_data;
                        sum_d   = csum_add(sum_q, in_data);
                        state_d = ST_LO;
                    end else begin
                        state_d = ST_HI;
                    end
                end
                ST_LO: begin
                    if (accept_s) begin
                        we_s  = 1'b1;
                        sum_d = csum_add(sum_q, in_data);
                        // Last word is the only exit; the counter never wraps
                        if (addr_q == ADDR_MAX) begin
                            if (CSUM_EN) begin
                                state_d = ST_CSUM;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            state_d = ST_HI;
                        end
                    end else begin
                        state_d = ST_LO;
                    end
                end
                ST_CSUM: begin
                    if (accept_s) begin
                        if (in_data == sum_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ERR;
                        end
                    end else begin
                        state_d = ST_CSUM;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    tiny_prog_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .reset_p (reset_p),
        .we_i    (we_s),
        .waddr_i (addr_q),
        .wdata_i ({hi_q, in_data}),
        .raddr_i (cpu_addr),
        .rdata_o (cpu_data)
    );

endmodule

// File: doc/tiny_prog_loader.md
# tiny_prog_loader

Program loader and instruction memory for the 4-bit tiny processor. It receives a 16-word × 8-bit program as a nibble stream over a valid/ready handshake and writes it into a RAM. It verifies a 4-bit checksum, then releases the processor. The processor reads the RAM through a combinational port that replaces its hard-coded ROM; this block is the writer side of that instruction-fetch interface.

## Interface
- `ADDR_W`, default 4: program address width. Depth is 2^ADDR_W words.
- `CSUM_EN`, default 1: 1 requires a trailing checksum nibble; 0 completes directly after the last data nibble.
- `clock` input, 1 bit: rising-edge clock.
- `reset_p` input, 1 bit: asynchronous, active-high reset.
- `load_start` input, 1 bit: single-cycle request to begin or restart a load.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_data` input, 4 bits: stream nibble, high nibble of each word first.
- `in_ready` output, 1 bit: loader accepts a nibble this cycle.
- `cpu_addr` input, ADDR_W bits: processor fetch address (PC).
- `cpu_data` output, 8 bits: `{INST, IMM}` at `cpu_addr`, combinational.
- `cpu_run` output, 1 bit: 1 lets the processor run; the processor's `reset_p` is driven by `!cpu_run | reset_p`.
- `busy` output, 1 bit: a load is in progress.
- `load_done` output, 1 bit: level, last load passed.
- `load_err` output, 1 bit: level, last load failed checksum.

## Operation
- A nibble is accepted only in a cycle where `in_valid` and `in_ready` are both 1. No other cycle affects state.
- States are IDLE, HI, LO, CSUM, DONE and ERR.
- **IDLE** (after reset): `in_ready` = 0.
  - `load_start` moves to HI with `addr` = 0 and `sum` = 0.
- **HI**: `in_ready` = 1.
  - On accept: `hi` <= `in_data`, `sum` <= `sum` + `in_data` (mod 16), move to LO.
- **LO**: `in_ready` = 1.
  - On accept: `mem[addr]` <= `{hi, in_data}` in the same edge, and `sum` <= `sum` + `in_data` (mod 16).
  - If `addr` < max, increment `addr` and return to HI.
  - If `addr` == max: go to CSUM when CSUM_EN = 1, or to DONE when CSUM_EN = 0.
- **CSUM**: `in_ready` = 1.
  - On accept: go to DONE if `in_data` == `sum`, otherwise go to ERR.
- **DONE**: `cpu_run` = 1, `load_done` = 1, `in_ready` = 0.
- **ERR**: `cpu_run` = 0, `load_err` = 1, `in_ready` = 0.
- `load_start` in any state, including mid-load, restarts the load:
  - State goes to HI, `addr` = 0, `sum` = 0.
  - `load_done`, `load_err` and `cpu_run` clear.
  - RAM contents are kept until overwritten.
  - If `load_start` and an accept occur in the same cycle, `load_start` wins and the nibble is dropped.
- `busy` = 1 in HI, LO and CSUM.
- `cpu_data` = `mem[cpu_addr]` at all times. Reads during a load return the current RAM contents; the processor is held in reset during a load anyway.
- The address counter never wraps within a load. The transition at `addr` == max is the only exit from LO.

## Timing
- Reset values:
  - State IDLE; `in_ready`, `cpu_run`, `busy`, `load_done`, `load_err` all 0.
  - All RAM words are 8'h00, so `cpu_data` = 8'h00.
- Outputs `in_ready`, `busy`, `cpu_run`, `load_done` and `load_err` are decoded from the registered state only, with no input-to-output combinational path. `cpu_data` is the only combinational output.
- After a `load_start` edge, `busy` = 1 and `in_ready` = 1 from the next cycle; `cpu_run` drops in that same cycle.
- A RAM write is visible on `cpu_data` in the cycle after the accepting edge.
- The minimum load is 2×2^ADDR_W + CSUM_EN accepted nibbles; at the default this is 33 cycles with back-to-back `in_valid`.
- `load_done` and `cpu_run` rise in the cycle after the final accept. The processor therefore begins fetching at PC = 0 one cycle later.
- Stalls: gaps in `in_valid` of any length are legal and change no state.

## Structure
- The shared package `tiny_pkg` holds:
  - the state enumeration;
  - `INST_W` = 4, `IMM_W` = 4 and `WORD_W` = 8;
  - the opcode constants used by both the processor decoder and bench program images.
- Sub-module `tiny_prog_ram`: 2^ADDR_W × 8 registers with async clear, one synchronous write port and one combinational read port. The loader FSM, counter and checksum live in the top level.

## Test plan
1. **Reset.** Assert `reset_p` mid-cycle → all outputs 0, `cpu_data` = 00 for every `cpu_addr`, `in_ready` = 0.
2. **Good load.**
   - Stream 1,9, F,2, 9,0 followed by 13×(0,0); checksum nibble 4 (0x24 mod 16).
   - Required: `load_done` = 1 and `cpu_run` = 1 one cycle after the last accept; `cpu_addr` = 1 gives `cpu_data` = F2; `cpu_addr` = 2 gives 90.
3. **Bad checksum.** Same image with checksum 5 → `load_err` = 1, `cpu_run` = 0, `load_done` = 0; RAM still holds 19, F2, 90.
4. **Backpressure and gaps.** Toggle `in_valid` randomly and hold `in_data` garbage while `in_valid` = 0 → identical result to scenario 2. With `in_valid` held high in IDLE or DONE, nothing is accepted.
5. **Restart mid-load.**
   - Pulse `load_start` after word 7, in the same cycle as a valid nibble. Then stream a full image of all 0x41, checksum 0x0 (16×5 = 80, 80 mod 16 = 0).
   - Required: the dropped nibble has no effect, `addr` restarts at 0, `load_done` = 1, and every word = 41.
6. **CSUM_EN = 0.** 32 nibbles → `load_done` = 1 immediately, with no wait for a 33rd nibble and `in_ready` = 0 afterwards.
